// File: rtl/arbiter_pkg.sv
// Shared types for the arbiter family: the two-state grant controller encoding.
package arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/priority_encoder.sv
// Lowest-index-wins priority encoder: reports the index of the lowest set bit
// and whether any bit is set at all.
module priority_encoder #(
    parameter int IW = 4
) (
    input  logic [IW-1:0]         i_in,
    output logic [$clog2(IW)-1:0] o_idx,
    output logic                  o_valid
);

    localparam int OW = $clog2(IW);

    // Scan from the top down so the lowest set bit is the last write.
    always_comb begin
        o_idx   = '0;
        o_valid = |i_in;
        for (int i = IW - 1; i >= 0; i--) begin
            if (i_in[i]) begin
                o_idx = OW'(i);
            end else begin
                o_idx = o_idx;
            end
        end
    end

endmodule

// File: rtl/round_robin_arbiter.sv
// Fair N-way round-robin arbiter with lock-until-release grants.
// Optional forced release after MAXHOLD cycles: LIBSV_ARBITERS_ROUND_ROBIN_ARBITER_TIMEOUT_EN.
module round_robin_arbiter
    import arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int MAXHOLD = 16
) (
    input  logic                 i_clock,
    input  logic                 i_aresetn,
    input  logic [N-1:0]         i_req,
    input  logic                 i_release,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_grant_idx,
    output logic                 o_grant_valid
`ifdef LIBSV_ARBITERS_ROUND_ROBIN_ARBITER_TIMEOUT_EN
    ,
    output logic                 o_timeout
`endif
);

    localparam int IW = $clog2(N);

    arb_state_e    state_q;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [N-1:0]  mask_s;
    logic [IW-1:0] m_idx_s;
    logic [IW-1:0] u_idx_s;
    logic [IW-1:0] win_idx_s;
    logic          m_valid_s;
    logic          u_valid_s;

`ifdef LIBSV_ARBITERS_ROUND_ROBIN_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(MAXHOLD + 1);
    logic [CW-1:0] hold_q;
`endif

    // Keep only requesters at or above the pointer for the first-choice search.
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < N; i++) begin
            if (i >= int'(ptr_q)) begin
                mask_s[i] = i_req[i];
            end else begin
                mask_s[i] = 1'b0;
            end
        end
    end

    priority_encoder #(.IW(N)) u_enc_masked (
        .i_in    (mask_s),
        .o_idx   (m_idx_s),
        .o_valid (m_valid_s)
    );

    priority_encoder #(.IW(N)) u_enc_unmasked (
        .i_in    (i_req),
        .o_idx   (u_idx_s),
        .o_valid (u_valid_s)
    );

    assign win_idx_s = m_valid_s ? m_idx_s : u_idx_s;

    // Holder drops to lowest priority; explicit wrap keeps non-power-of-two N correct.
    always_comb begin
        if (o_grant_idx == IW'(N - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = o_grant_idx + 1'b1;
        end
    end

    // Grant controller: state, pointer, registered grant outputs and hold counter.
    always_ff @(posedge i_clock or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            o_grant       <= '0;
            o_grant_idx   <= '0;
            o_grant_valid <= 1'b0;
`ifdef LIBSV_ARBITERS_ROUND_ROBIN_ARBITER_TIMEOUT_EN
            hold_q        <= '0;
            o_timeout     <= 1'b0;
`endif
        end else begin
`ifdef LIBSV_ARBITERS_ROUND_ROBIN_ARBITER_TIMEOUT_EN
            o_timeout <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (u_valid_s) begin
                        state_q       <= BUSY;
                        o_grant       <= {{(N-1){1'b0}}, 1'b1} << win_idx_s;
                        o_grant_idx   <= win_idx_s;
                        o_grant_valid <= 1'b1;
`ifdef LIBSV_ARBITERS_ROUND_ROBIN_ARBITER_TIMEOUT_EN
                        hold_q        <= '0;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    if (i_release) begin
                        state_q       <= IDLE;
                        ptr_q         <= ptr_d;
                        o_grant       <= '0;
                        o_grant_idx   <= '0;
                        o_grant_valid <= 1'b0;
`ifdef LIBSV_ARBITERS_ROUND_ROBIN_ARBITER_TIMEOUT_EN
                    end else if (hold_q == CW'(MAXHOLD - 1)) begin
                        state_q       <= IDLE;
                        ptr_q         <= ptr_d;
                        o_grant       <= '0;
                        o_grant_idx   <= '0;
                        o_grant_valid <= 1'b0;
                        o_timeout     <= 1'b1;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
`else
                    end else begin
                        state_q <= BUSY;
                    end
`endif
                end
                default: begin
                    state_q       <= IDLE;
                    o_grant       <= '0;
                    o_grant_idx   <= '0;
                    o_grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Randomized self-checking bench for round_robin_arbiter against a rotating-search
// reference model; timeout checks follow LIBSV_ARBITERS_ROUND_ROBIN_ARBITER_TIMEOUT_EN.
module tb_round_robin_arbiter;

    localparam int N       = 4;
    localparam int MAXHOLD = 4;
`ifdef LIBSV_ARBITERS_ROUND_ROBIN_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                 clk;
    logic                 rst_n;
    logic [N-1:0]         req;
    logic                 rel;
    logic [N-1:0]         grant;
    logic [$clog2(N)-1:0] grant_idx;
    logic                 grant_valid;
    logic                 timeout;

    int n_checks;
    int n_fail;

    // Reference model state
    bit m_busy;
    int m_idx;
    int m_ptr;
    int m_cnt;
    bit m_to;

    round_robin_arbiter #(.N(N), .MAXHOLD(MAXHOLD)) dut (
        .i_clock       (clk),
        .i_aresetn     (rst_n),
        .i_req         (req),
        .i_release     (rel),
        .o_grant       (grant),
        .o_grant_idx   (grant_idx),
        .o_grant_valid (grant_valid)
`ifdef LIBSV_ARBITERS_ROUND_ROBIN_ARBITER_TIMEOUT_EN
        ,
        .o_timeout     (timeout)
`endif
    );

`ifndef LIBSV_ARBITERS_ROUND_ROBIN_ARBITER_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_idx  = 0;
        m_ptr  = 0;
        m_cnt  = 0;
        m_to   = 1'b0;
    endtask

    // One rising edge as the specification describes it: search requesters
    // starting at the pointer and wrapping around.
    task automatic model_edge(input logic [N-1:0] r, input logic rl);
        m_to = 1'b0;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!m_busy && r[j]) begin
                    m_busy = 1'b1;
                    m_idx  = j;
                    m_cnt  = 0;
                end
            end
        end else if (rl) begin
            m_busy = 1'b0;
            m_ptr  = (m_idx + 1) % N;
        end else if (TO_EN && m_cnt == MAXHOLD - 1) begin
            m_busy = 1'b0;
            m_ptr  = (m_idx + 1) % N;
            m_to   = 1'b1;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [N-1:0] eg;
        eg = m_busy ? (N'(1) << m_idx) : '0;
        check_eq({tag, ".grant"}, 32'(grant), 32'(eg));
        check_eq({tag, ".idx"}, 32'(grant_idx), m_busy ? 32'(m_idx) : 32'd0);
        check_eq({tag, ".valid"}, 32'(grant_valid), 32'(m_busy));
        check_eq({tag, ".timeout"}, 32'(timeout), 32'(m_to));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge(req, rel);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        req      = '0;
        rel      = 1'b0;
        rst_n    = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single request, then release moves the pointer to 3
        req = 4'b0100;
        step("single");
        check_eq("single.lit", 32'(grant), 32'h4);
        req = 4'b0000;
        rel = 1'b1;
        step("single_rel");
        rel = 1'b0;

        // Pointer 3 with only lower requests falls back to the unmasked search
        req = 4'b0011;
        step("wrap");
        check_eq("wrap.lit", 32'(grant), 32'h1);
        rel = 1'b1;
        req = 4'b0000;
        step("wrap_rel");
        rel = 1'b0;
        req = 4'b1001;
        step("mask");
        check_eq("mask.lit", 32'(grant), 32'h8);
        rel = 1'b1;
        req = 4'b0000;
        step("mask_rel");

        // Full contention with release held high
        req = 4'b1111;
        rel = 1'b1;
        for (int i = 0; i < 12; i++) step("contend");

        // Locked grant while requests wander and release stays low
        rel = 1'b0;
        req = 4'b0010;
        step("lock_start");
        for (int i = 0; i < 10; i++) begin
            req = N'($urandom);
            step("lock");
        end
        rel = 1'b1;
        step("lock_rel");
        rel = 1'b0;

        // Asynchronous reset in the middle of a grant
        req = 4'b1111;
        step("pre_rst");
        if (!m_busy) step("pre_rst2");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("async_rst.grant", 32'(grant), 32'h0);
        check_eq("async_rst.valid", 32'(grant_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1111;
        step("post_rst");
        check_eq("post_rst.lit", 32'(grant), 32'h1);

        // Long hold with no release exercises the timeout when compiled in
        rel = 1'b0;
        for (int i = 0; i < 8; i++) step("hold");
        rel = 1'b1;
        step("hold_rel");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            req = N'($urandom);
            rel = ($urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/round_robin_arbiter.md
# round_robin_arbiter

Shares one resource among `N` requesters with a fair, lock-until-release grant. Arbitration is a masked/unmasked priority encode rotated by a registered pointer, so the most recently served requester drops to lowest priority. The block sits in front of a shared datapath such as a bus port or a single-ported memory. It sequences exclusive access through a two-state controller.

## Interface
- `N`, default 4: number of requesters; legal range N ≥ 2; non-power-of-two values are legal.
- `MAXHOLD`, default 16: maximum grant length in cycles; legal range ≥ 1; used only when the timeout is compiled in.
- `i_clock` input 1: the single clock; all state updates on its rising edge.
- `i_aresetn` input 1: asynchronous, active-low reset.
- `i_req` input N: per-requester request level; bit i is requester i.
- `i_release` input 1: the current holder is done; sampled only while busy.
- `o_grant` output N: registered one-hot grant, or all-zero.
- `o_grant_idx` output $clog2(N): index of the granted requester; 0 when idle.
- `o_grant_valid` output 1: high while any grant is held; equals |o_grant.
- `o_timeout` output 1: one-cycle pulse on a forced release. This port exists only with the macro defined.

## Operation
- States:
  - IDLE: no grant held.
  - BUSY: one grant held.
- Reset values, all asynchronous:
  - state = IDLE.
  - o_grant = 0, o_grant_idx = 0, o_grant_valid = 0, o_timeout = 0.
  - pointer = 0, hold counter = 0.
- Arbitration in IDLE, with at least one i_req bit set at the edge:
  - mask = the i_req bits at index ≥ pointer.
  - If mask ≠ 0, the winner is the lowest set bit of mask.
  - Otherwise the winner is the lowest set bit of i_req.
  - Next state is BUSY, with o_grant = 1<<winner and o_grant_idx = winner.
- IDLE with i_req = 0: stay in IDLE; i_release is ignored.
- BUSY:
  - The grant is locked. Changes on i_req, including the holder dropping its own request, have no effect.
  - When i_release is sampled high, the grant clears and the state returns to IDLE.
  - On that same edge, pointer = (o_grant_idx + 1) mod N, with explicit wrap from N−1 to 0.
- No back-to-back grants: IDLE always lasts at least one cycle between grants.
- Fairness: with all requesters continuously requesting, grants cycle 0, 1, …, N−1, 0, …
- Reset mid-grant: the grant drops immediately on i_aresetn falling, with no dependence on the clock. After reset deassertion, arbitration restarts from pointer 0.

## Timing
- Request to grant latency is 1 edge. A request present at edge k in IDLE produces a grant visible from edge k onward, i.e. for cycle k+1.
- Release to grant removal is 1 edge. At edge j with i_release high, o_grant is 0 for cycle j+1.
- Next grant is decided at edge j+1, so the gap between grants is exactly 1 cycle when requests are pending.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `LIBSV_ARBITERS_ROUND_ROBIN_ARBITER_TIMEOUT_EN`
- Defined:
  - A hold counter resets to 0 on entry to BUSY and increments each BUSY cycle.
  - When the counter reaches MAXHOLD−1 at an edge with i_release low, the block forces a release: grant cleared, pointer advanced exactly as for a normal release, and o_timeout high for one cycle.
  - If i_release and the timeout coincide, the release is treated as normal and o_timeout stays 0.
- Not defined:
  - No counter and no o_timeout port.
  - A grant is held indefinitely until i_release.

## Structure
- Package `arbiter_pkg`: the state enum typedef (IDLE, BUSY).
- One sub-module: the existing `priority_encoder`, instantiated twice with IW=N.
  - One instance encodes the masked requests, the other the unmasked requests.
  - The masked result is selected when its o_valid is high.
- Pointer, state, grant registers and hold counter live in the top-level module.

## Test plan
- Reset, single request: hold i_aresetn low, then release it and set i_req=0100 with N=4 → o_grant=0100 and o_grant_idx=2 one edge later. Pulse i_release → grant 0 next cycle, pointer=3.
- Full contention: i_req=1111 held, i_release pulsed every cycle while granted → grant sequence 0001, 0010, 0100, 1000, 0001, with one idle cycle between each.
- Wrap and mask: pointer=3 with i_req=0011 → grant 0001 (unmasked fallback). Then i_req=1001 with pointer=1 → grant 1000.
- Lock: grant 0010 held, i_req changes to 1101 and i_release stays low → o_grant stays 0010 for 10 cycles.
- Reset mid-grant: drop i_aresetn between clock edges while granted → o_grant=0 immediately. After reset deassertion, i_req=1111 → grant 0001.
- Timeout (macro defined, MAXHOLD=4): grant with no release → grant drops after 4 BUSY cycles and o_timeout pulses for 1 cycle. With release on the 4th cycle → o_timeout stays 0.
